// File: rtl/cla_nibble_seq_adder_if.sv
// Operand/result handshake bundle for the nibble-serial CLA adder/subtractor.
// The bench drives through master; the adder sits on slave.
interface cla_nibble_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/cla_nibble_seq_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one shared 4-bit carry-lookahead slice,
// one nibble per clock LSB first, carry held in a register between passes.

module cla_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Every carry is formed directly from generate/propagate terms, no ripple.
    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_i);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_i);

    assign s_o = p ^ c[3:0];
    assign c_o = c[4];
endmodule

module cla_nibble_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cla_nibble_seq_adder_if.slave  bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [3:0]         nib_s;
    logic               nib_c;
    logic               last_nib;
    logic [WIDTH-1:0]   res_shift;

    cla_4bit u_slice (
        .a_i (opa_q[3:0]),
        .b_i (opb_q[3:0]),
        .c_i (carry_q),
        .s_o (nib_s),
        .c_o (nib_c)
    );

    assign last_nib  = (cnt_q == CNT_W'(NIB - 1));
    // New nibble enters at the MSB end so after NIB passes the word is in place.
    assign res_shift = (res_q >> 4) | (WIDTH'(nib_s) << (WIDTH - 4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.in_valid)  state_d = S_RUN;
            S_RUN:  if (last_nib)      state_d = S_DONE;
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction is a + ~b + 1; cin is deliberately ignored there.
                    opa_d   = bus.a;
                    opb_d   = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                opa_d   = opa_q >> 4;
                opb_d   = opb_q >> 4;
                res_d   = res_shift;
                carry_d = nib_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_nib) begin
                    sum_d  = res_shift;
                    cout_d = nib_c;
                    cnt_d  = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.sum       = sum_q;
        bus.cout      = cout_q;
    end
endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Self-checking bench for cla_nibble_seq_adder: directed cases, back-pressure,
// mid-operation reset and randomized traffic against an arithmetic reference.
module tb_cla_nibble_seq_adder;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    cla_nibble_seq_adder_if #(.WIDTH(WIDTH)) bus ();

    cla_nibble_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, subtraction as a true difference.
    function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic cin, input logic sub);
        logic [WIDTH:0] r;
        if (sub) begin
            r[WIDTH-1:0] = a - b;
            r[WIDTH]     = (a >= b);
        end else begin
            r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        end
        return r;
    endfunction

    // Called at a negedge with the block idle; returns at a negedge.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub, input bit hold,
                         output logic [WIDTH:0] expv);
        int n;
        expv = ref_op(a, b, cin, sub);
        check("in_ready_before", 32'(bus.in_ready), 32'd1);
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            // Garbage while busy must be ignored by the block.
            bus.in_valid  = 1'($urandom);
            bus.a         = WIDTH'($urandom);
            bus.b         = WIDTH'($urandom);
            bus.out_ready = 1'($urandom);
            check("in_ready_busy", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("latency", 32'(n), 32'(NIB));
        check("sum", 32'(bus.sum), 32'(expv[WIDTH-1:0]));
        check("cout", 32'(bus.cout), 32'(expv[WIDTH]));
        if (!hold) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.out_ready = 1'b0;
            check("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
            check("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [WIDTH:0] e;
        logic [WIDTH:0] held;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, e);
        check("dir_3p5", 32'(bus.sum), 32'h0008);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, e);
        check("dir_ripple", {15'd0, bus.cout, bus.sum}, 32'h1_0000);
        do_op(16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b0, e);
        check("dir_aa55", {15'd0, bus.cout, bus.sum}, 32'h1_0000);
        do_op(16'h0006, 16'h0003, 1'b1, 1'b1, 1'b0, e);
        check("dir_6m3", {15'd0, bus.cout, bus.sum}, 32'h1_0003);
        do_op(16'h0003, 16'h0006, 1'b0, 1'b1, 1'b0, e);
        check("dir_3m6", {15'd0, bus.cout, bus.sum}, 32'h0_FFFD);

        // Back-pressure: result held, pulsed in_valid not accepted.
        do_op(16'h1357, 16'h2468, 1'b0, 1'b0, 1'b1, held);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'(i & 1);
            bus.a = WIDTH'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_sum", 32'(bus.sum), 32'(held[WIDTH-1:0]));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_release_ov", 32'(bus.out_valid), 32'd0);
        check("bp_release_ir", 32'(bus.in_ready), 32'd1);
        do_op(16'h0100, 16'h0200, 1'b1, 1'b0, 1'b0, e);

        // Reset asynchronously in the second RUN cycle.
        do_op(16'h0003, 16'h0006, 1'b0, 1'b1, 1'b0, e);
        bus.a = 16'h00FF; bus.b = 16'h0001; bus.sub = 1'b0; bus.cin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_sum", 32'(bus.sum), 32'd0);
        check("mid_rst_cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 32'(bus.out_valid), 32'd0);
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, e);
        check("post_rst_op", {15'd0, bus.cout, bus.sum}, 32'h0_2345);

        for (int k = 0; k < 60; k++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'b0, e);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
